spi_slave_command_logger: RTL and testbench

SPI_SLAVE_COMMAND_LOGGER -- requirements
Module: spi_slave_command_logger

---
 rtl/spi_slave_command_logger.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_command_logger.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_command_logger.sv
// SPI slave command logger: timestamps every completed SPI command into a circular
// FIFO that a host drains over a 64-bit Avalon-MM slave with one read wait state.
module spi_slave_command_logger #(
  parameter int CMD_W      = 6,
  parameter int ARG_W      = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int TS_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       io_Avalon_address,
  input  logic             io_Avalon_read,
  input  logic             io_Avalon_write,
  input  logic [63:0]      io_Avalon_writedata,
  output logic [63:0]      io_Avalon_readdata,
  output logic             io_Avalon_waitrequest,
  input  logic [CMD_W-1:0] io_Command,
  input  logic [ARG_W-1:0] io_CommandArgument,
  input  logic             io_ArgumentReadFinished
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ENT_W = TS_W + CMD_W + ARG_W;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [TS_W-1:0]       ONE_TS   = {{(TS_W-1){1'b0}}, 1'b1};

  generate
    if (ENT_W > 64) begin : g_width_check
      $error("spi_slave_command_logger: TS_W+CMD_W+ARG_W must not exceed 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    ADDR_STATUS  = 2'd0,
    ADDR_CONTROL = 2'd1,
    ADDR_DATA    = 2'd2,
    ADDR_DROPS   = 2'd3
  } reg_addr_e;

  logic [ENT_W-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [TS_W-1:0]       ts_q;
  logic [31:0]           drops_q, drops_d;
  logic                  hist_q, enable_q, enable_d, wrap_q, wrap_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  rd_phase_q;
  logic [63:0]           readdata_q, readdata_d;

  reg_addr_e             addr;
  logic [ENT_W-1:0]      entry;
  logic                  mem_we, rd_first, pop, ctl_wr, clear, capture, empty, full;
  logic                  unused_wdata;

  assign addr         = reg_addr_e'(io_Avalon_address);
  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign entry        = {ts_q, io_Command, io_CommandArgument};
  assign rd_first     = io_Avalon_read && !rd_phase_q;
  assign pop          = io_Avalon_read && rd_phase_q && (addr == ADDR_DATA);
  assign ctl_wr       = io_Avalon_write && !io_Avalon_read && (addr == ADDR_CONTROL);
  assign clear        = ctl_wr && io_Avalon_writedata[2];
  assign capture      = enable_q && io_ArgumentReadFinished && !hist_q;
  assign unused_wdata = ^io_Avalon_writedata[63:3];

  // Reset gates the strobe so a read caught by reset drops its wait state at once.
  assign io_Avalon_waitrequest = rd_first && reset;
  assign io_Avalon_readdata    = readdata_q;

  // Register file snapshot taken at the end of the wait-state cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    readdata_d = '0;
    if (rd_first) begin
      case (addr)
        ADDR_STATUS: begin
          readdata_d[DEPTH_LOG2+8:8] = count_q;
          readdata_d[3:0]            = {underflow_q, overflow_q, full, empty};
        end
        ADDR_CONTROL: readdata_d[1:0]  = {wrap_q, enable_q};
        ADDR_DATA:    if (!empty) readdata_d = 64'(mem_q[rd_ptr_q]);
        ADDR_DROPS:   readdata_d[31:0] = drops_q;
        default:      readdata_d = '0;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    drops_d     = drops_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    enable_d    = enable_q;
    wrap_d      = wrap_q;
    mem_we      = 1'b0;
    if (ctl_wr) begin
      enable_d = io_Avalon_writedata[0];
      wrap_d   = io_Avalon_writedata[1];
    end
    if (clear) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      drops_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // NOTE: blocking updates here are intentional: the pop result feeds the capture decision.
      if (pop) begin
        if (count_d == '0) begin
          underflow_d = 1'b1;
        end else begin
          rd_ptr_d = rd_ptr_d + ONE_PTR;
          count_d  = count_d - ONE_CNT;
        end
      end
      if (capture) begin
        if (count_d != FULL_CNT) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_d + ONE_PTR;
          count_d  = count_d + ONE_CNT;
        end else begin
          overflow_d = 1'b1;
          if (drops_q != '1) drops_d = drops_q + 32'd1;
          if (wrap_q) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_d + ONE_PTR;
            rd_ptr_d = rd_ptr_d + ONE_PTR;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ts_q        <= '0;
      drops_q     <= '0;
      hist_q      <= 1'b1;
      enable_q    <= 1'b1;
      wrap_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_phase_q  <= 1'b0;
      readdata_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ts_q        <= ts_q + ONE_TS;
      drops_q     <= drops_d;
      hist_q      <= io_ArgumentReadFinished;
      enable_q    <= enable_d;
      wrap_q      <= wrap_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_phase_q  <= rd_first;
      readdata_q  <= readdata_d;
    end
  end

  // NOTE: the entry array is deliberately not reset; count and pointers alone define validity.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[wr_ptr_q] <= entry;
  end

endmodule

// File: tb/tb_spi_slave_command_logger.sv
// Self-checking bench for spi_slave_command_logger: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_spi_slave_command_logger;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [63:0] wdata = '0;
  logic [63:0] readdata;
  logic        waitrequest;
  logic [5:0]  cmd = '0;
  logic [31:0] arg = '0;
  logic        arf = 1'b0;

  always #5 clk = ~clk;

  spi_slave_command_logger dut (
    .clock                  (clk),
    .reset                  (rst_n),
    .io_Avalon_address      (addr),
    .io_Avalon_read         (read),
    .io_Avalon_write        (write),
    .io_Avalon_writedata    (wdata),
    .io_Avalon_readdata     (readdata),
    .io_Avalon_waitrequest  (waitrequest),
    .io_Command             (cmd),
    .io_CommandArgument     (arg),
    .io_ArgumentReadFinished(arf)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;
  bit rand_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mq[$];
  logic [31:0] m_drops;
  logic        m_ovf, m_unf, m_en, m_wrap, m_hist, m_rd_pending;
  logic [15:0] m_ts;
  logic [63:0] m_rdata;
  int          edges;

  function automatic logic [63:0] m_regval(input logic [1:0] a);
    case (a)
      2'd0: return (64'(mq.size()) << 8) |
                   {60'd0, m_unf, m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
      2'd1: return {62'd0, m_wrap, m_en};
      2'd2: return (mq.size() == 0) ? 64'd0 : mq[0];
      default: return {32'd0, m_drops};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic        cap, pop, ctl;
    logic [63:0] ent, nd;
    if (!rst_n) begin
      mq.delete();
      m_drops = '0; m_ovf = 0; m_unf = 0; m_en = 1; m_wrap = 0;
      m_hist = 1; m_rd_pending = 0; m_ts = '0; m_rdata = '0;
    end else begin
      cap = m_en && arf && !m_hist;
      ent = {10'd0, m_ts, cmd, arg};
      pop = read && m_rd_pending && (addr == 2'd2);
      ctl = write && !read && (addr == 2'd1);
      nd  = '0;
      if (read && !m_rd_pending) begin
        nd = m_regval(addr);
        m_rd_pending = 1;
      end else begin
        m_rd_pending = 0;
      end
      if (ctl && wdata[2]) begin
        mq.delete();
        m_drops = '0; m_ovf = 0; m_unf = 0;
      end else begin
        if (pop) begin
          if (mq.size() == 0) m_unf = 1;
          else void'(mq.pop_front());
        end
        if (cap) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(ent);
          end else begin
            m_ovf = 1;
            if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
            if (m_wrap) begin
              void'(mq.pop_front());
              mq.push_back(ent);
            end
          end
        end
      end
      if (ctl) begin
        m_en   = wdata[0];
        m_wrap = wdata[1];
      end
      m_hist  = arf;
      m_ts    = m_ts + 1;
      m_rdata = nd;
    end
  end

  // Independent count of clock edges since reset release: the timestamp a capture must carry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("waitrequest", 64'(waitrequest), 64'(read && !m_rd_pending));
      check("readdata", readdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
    if (rand_mode) begin
      arf = 1'($urandom_range(0, 1));
      cmd = 6'($urandom);
      arg = $urandom;
    end
  endtask

  task automatic av_read(input logic [1:0] a, input bit also_write, output logic [63:0] d);
    int n;
    n    = 0;
    addr = a;
    read = 1'b1;
    if (also_write) begin
      write = 1'b1;
      wdata = 64'h6;
    end
    #1;
    check("rd_wait_first", 64'(waitrequest), 64'd1);
    while (waitrequest && n < 4) begin
      step();
      n++;
    end
    check("rd_wait_bound", 64'(waitrequest), 64'd0);
    d = readdata;
    step();
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic av_write(input logic [1:0] a, input logic [63:0] d);
    addr  = a;
    wdata = d;
    write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic pulse(input logic [5:0] c, input logic [31:0] g, output int ts);
    cmd = c;
    arg = g;
    arf = 1'b1;
    ts  = edges;
    step();
    arf = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int          ts0, r;
    logic [5:0]  c;

    // Reset values, with a read strobe held to prove waitrequest stays low.
    read = 1'b1;
    #1;
    check("reset_wait", 64'(waitrequest), 64'd0);
    check("reset_rdata", readdata, 64'd0);
    read = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    step();

    // Single capture then pop.
    pulse(6'h2A, 32'hDEAD_BEEF, ts0);
    av_read(2'd2, 1'b0, d);
    check("cap_cmdarg", 64'(d[37:0]), 64'({6'h2A, 32'hDEAD_BEEF}));
    check("cap_ts", 64'(d[53:38]), 64'(ts0));
    check("cap_upper_zero", 64'(d[63:54]), 64'd0);
    av_read(2'd0, 1'b0, d);
    check("status_empty", d, 64'h1);

    // Underflow on empty pop.
    av_read(2'd2, 1'b0, d);
    check("underflow_data", d, 64'd0);
    av_read(2'd0, 1'b0, d);
    check("underflow_status", d, 64'h9);

    av_write(2'd1, 64'h5);
    av_read(2'd1, 1'b0, d);
    check("ctrl_after_clear", d, 64'h1);
    av_read(2'd0, 1'b0, d);
    check("status_after_clear", d, 64'h1);

    // Overflow without wrap: oldest survives.
    for (int i = 1; i <= 66; i++) pulse(6'(i), 32'hA000_0000 + 32'(i), ts0);
    av_read(2'd0, 1'b0, d);
    check("nowrap_status", d, 64'h4006);
    av_read(2'd3, 1'b0, d);
    check("nowrap_drops", d, 64'd2);
    av_read(2'd2, 1'b0, d);
    check("nowrap_first", 64'(d[37:0]), 64'({6'd1, 32'hA000_0001}));

    // Clear after overflow.
    av_write(2'd1, 64'h5);
    av_read(2'd0, 1'b0, d);
    check("clr_status", d, 64'h1);
    av_read(2'd3, 1'b0, d);
    check("clr_drops", d, 64'd0);
    av_read(2'd1, 1'b0, d);
    check("clr_ctrl", d, 64'h1);

    // Overflow with wrap: two oldest overwritten.
    av_write(2'd1, 64'h3);
    for (int i = 1; i <= 66; i++) pulse(6'(i), 32'hA000_0000 + 32'(i), ts0);
    av_read(2'd3, 1'b0, d);
    check("wrap_drops", d, 64'd2);
    av_read(2'd0, 1'b0, d);
    check("wrap_status", d, 64'h4006);
    av_read(2'd2, 1'b0, d);
    check("wrap_first", 64'(d[37:0]), 64'({6'd3, 32'hA000_0003}));

    // Refill to full, then capture on the very edge that pops.
    av_write(2'd1, 64'h1);
    pulse(6'h3F, 32'h5555_0000, ts0);
    addr = 2'd2;
    read = 1'b1;
    step();
    cmd = 6'h15;
    arg = 32'h1234_5678;
    arf = 1'b1;
    d   = readdata;
    step();
    read = 1'b0;
    arf  = 1'b0;
    check("pop_cap_oldest", 64'(d[37:0]), 64'({6'd4, 32'hA000_0004}));
    av_read(2'd0, 1'b0, d);
    check("pop_cap_status", d, 64'h4006);
    av_read(2'd3, 1'b0, d);
    check("pop_cap_drops", d, 64'd2);

    // Read and write together: the write (a clear) must be ignored.
    av_read(2'd1, 1'b1, d);
    check("rw_ctrl", d, 64'h1);
    av_read(2'd0, 1'b0, d);
    check("rw_status_kept", d, 64'h4006);

    // Randomized traffic, checked every cycle by the model.
    rand_mode = 1'b1;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        av_read(2'($urandom), ($urandom_range(0, 4) == 0), d);
      end else if (r == 4) begin
        av_write(2'd1, {61'd0, ($urandom_range(0, 7) == 0), 1'($urandom),
                        ($urandom_range(0, 7) != 0)});
      end else if (r == 5) begin
        av_write(2'($urandom), {32'($urandom), 32'($urandom)});
      end else begin
        step();
      end
    end
    rand_mode = 1'b0;
    arf = 1'b0;
    step();

    // Reset during the data cycle of a pending read.
    c = 6'h11;
    pulse(c, 32'h0BAD_F00D, ts0);
    addr = 2'd2;
    read = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_wait", 64'(waitrequest), 64'd0);
    check("rst_mid_rdata", readdata, 64'd0);
    read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    av_read(2'd0, 1'b0, d);
    check("rst_mid_status", d, 64'h1);

    // Reset during the wait-state cycle.
    addr = 2'd0;
    read = 1'b1;
    #1;
    check("rst_first_wait_hi", 64'(waitrequest), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_first_wait_lo", 64'(waitrequest), 64'd0);
    read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    av_read(2'd3, 1'b0, d);
    check("rst_first_drops", d, 64'd0);

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
